sat_addsub_seq: RTL and testbench

Parametrised multi-cycle saturating adder/subtractor for the ALU datapath; generalises the 16-bit CLA add/sub to any width.
- Processes CHUNK bits per cycle under a small FSM with a start/busy/done handshake.
- Supports full-width signed add/sub and packed per-lane saturating add/sub (PADDSB-style).
- Registers results and the N/Z/V flags for the flag register.

---
 rtl/sat_addsub_seq.sv | 205 ++++++++++++++++++++
 tb/tb_sat_addsub_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_addsub_seq.sv
// ----------------------------------------------------------------------------
// sat_addsub_seq
//
// Multi-cycle saturating adder/subtractor. Operands are summed CHUNK bits per
// cycle, then a single saturation cycle clamps the full word (ops 00/01) or
// each LANE-bit lane independently (ops 10/11) to its signed range.
//
// Optional feature macro: SAT_ADDSUB_STICKY_EN
//   When defined, adds clr_sticky / ovf_sticky, a sticky overflow indicator
//   that sets on any done with an overflow (full or any lane).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   operation request, sampled only while idle
//   a, b       in   WIDTH-bit two's complement operands
//   op         in   00 add, 01 sub, 10 packed add, 11 packed sub
//   busy       out  high while an operation is in flight
//   done       out  one-cycle pulse, result/flags valid from this cycle
//   result     out  saturated result, held until the next done
//   N, Z, V    out  negative / zero / raw overflow, full-width ops only
//   clr_sticky in   (optional) clear the sticky overflow bit
//   ovf_sticky out  (optional) sticky overflow bit
// ----------------------------------------------------------------------------
module sat_addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             N,
    output logic             Z,
    output logic             V
`ifdef SAT_ADDSUB_STICKY_EN
    ,
    input  logic             clr_sticky,
    output logic             ovf_sticky
`endif
);

    localparam int K   = WIDTH / CHUNK;   // RUN cycles per operation
    localparam int CPL = LANE / CHUNK;    // chunks per lane
    localparam int NL  = WIDTH / LANE;    // lanes per word
    localparam int IW  = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SAT} state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;
    logic             r_sub;
    logic             r_packed;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_n;
    logic             r_z;
    logic             r_v;
    logic             r_done;

    logic [K-1:0]     w_lane_start;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic             w_cin;
    logic [CHUNK:0]   w_chunk_sum;
    logic [NL-1:0]    w_lane_ovf;
    logic [WIDTH-1:0] w_lane_res;
    logic             w_full_ovf;
    logic [WIDTH-1:0] w_full_res;
    logic [WIDTH-1:0] w_sat_result;
    logic             w_any_ovf;

    // Marks chunks that begin a lane; in packed ops the carry chain is cut
    // there and reloaded with the subtract "+1" so lanes stay independent.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_lane_start
            assign w_lane_start[gi] = ((gi % CPL) == 0);
        end
    endgenerate

    assign w_a_ch      = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_ch      = r_b[r_idx*CHUNK +: CHUNK];
    assign w_cin       = (r_packed && w_lane_start[r_idx]) ? r_sub : r_carry;
    assign w_chunk_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, w_cin};

    // Per-lane overflow and clamp: operands agree in sign but the sum does not.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane_sat
            localparam int MSB = gi*LANE + LANE - 1;
            assign w_lane_ovf[gi] = (r_a[MSB] == r_b[MSB]) && (r_sum[MSB] != r_a[MSB]);
            assign w_lane_res[gi*LANE +: LANE] = w_lane_ovf[gi]
                ? {r_a[MSB], {(LANE-1){~r_a[MSB]}}}
                : r_sum[gi*LANE +: LANE];
        end
    endgenerate

    assign w_full_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);
    assign w_full_res   = w_full_ovf ? {r_a[WIDTH-1], {(WIDTH-1){~r_a[WIDTH-1]}}} : r_sum;
    assign w_sat_result = r_packed ? w_lane_res : w_full_res;
    assign w_any_ovf    = r_packed ? (|w_lane_ovf) : w_full_ovf;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_idx == IW'(K-1)) w_state_next = S_SAT;
            S_SAT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (r_state != S_IDLE);
        done   = r_done;
        result = r_result;
        N      = r_n;
        Z      = r_z;
        V      = r_v;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_sub    <= 1'b0;
            r_packed <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_SAT);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b ^ {WIDTH{op[0]}};
                        r_sub    <= op[0];
                        r_packed <= op[1];
                        r_carry  <= op[0];
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                    r_carry <= w_chunk_sum[CHUNK];
                    r_idx   <= r_idx + 1'b1;
                end
                S_SAT: begin
                    r_result <= w_sat_result;
                    if (!r_packed) begin
                        r_n <= w_sat_result[WIDTH-1];
                        r_z <= (w_sat_result == '0);
                        r_v <= w_full_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAT_ADDSUB_STICKY_EN
    // Set has priority over clear when both occur in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (r_state == S_SAT && w_any_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_any_ovf;
`endif

endmodule

// File: tb/tb_sat_addsub_seq.sv
module tb_sat_addsub_seq;

    localparam int W = 16;
    localparam int L = 4;
    localparam int LAT = 5;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         N;
    logic         Z;
    logic         V;
`ifdef SAT_ADDSUB_STICKY_EN
    logic         clr_sticky;
    logic         ovf_sticky;
    logic         exp_sticky;
`endif

    int tests_run;
    int tests_failed;

    logic         exp_n, exp_z, exp_v;
    logic [W-1:0] last_exp;

    sat_addsub_seq #(.WIDTH(W), .CHUNK(4), .LANE(L)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .N      (N),
        .Z      (Z),
        .V      (V)
`ifdef SAT_ADDSUB_STICKY_EN
        ,
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true signed arithmetic clamped to the representable range.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] top,
                         output logic [W-1:0] res, output logic ovf);
        int x, y, r, lo, hi, bits, nl;
        logic [W-1:0] tmp;
        ovf  = 1'b0;
        tmp  = '0;
        bits = top[1] ? L : W;
        nl   = top[1] ? W / L : 1;
        hi   = (1 << (bits - 1)) - 1;
        lo   = -(1 << (bits - 1));
        for (int l = 0; l < nl; l++) begin
            x = 0;
            y = 0;
            for (int k = 0; k < bits; k++) begin
                x = x + (int'(ta[l*bits + k]) << k);
                y = y + (int'(tb_v[l*bits + k]) << k);
            end
            if (x > hi) x = x - (1 << bits);
            if (y > hi) y = y - (1 << bits);
            r = top[0] ? (x - y) : (x + y);
            if (r > hi) begin r = hi; ovf = 1'b1; end
            if (r < lo) begin r = lo; ovf = 1'b1; end
            for (int k = 0; k < bits; k++) tmp[l*bits + k] = r[k];
        end
        res = tmp;
    endtask

    // Issues one op (immediately if imm, else at the next negedge), checks
    // latency, result and flags. Returns positioned #1 after the done edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] top,
                          input bit imm, input string tag);
        logic [W-1:0] er;
        logic         ev;
        int           cycles;
        model(ta, tb_v, top, er, ev);
        if (!imm) @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        op    = top;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        op     = 2'($urandom);
        cycles = 0;
        while (!done && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!top[1]) begin
            exp_n = er[W-1];
            exp_z = (er == '0);
            exp_v = ev;
        end
        last_exp = er;
        $display("[TB] %s op=%0d a=%h b=%h -> result=%h NZV=%b%b%b lat=%0d", tag, top, ta, tb_v,
                 result, N, Z, V, cycles);
        check({tag, ".lat"}, cycles, LAT);
        check({tag, ".res"}, result, er);
        check({tag, ".N"}, N, exp_n);
        check({tag, ".Z"}, Z, exp_z);
        check({tag, ".V"}, V, exp_v);
`ifdef SAT_ADDSUB_STICKY_EN
        if (ev) exp_sticky = 1'b1;
        check({tag, ".sticky"}, ovf_sticky, exp_sticky);
`endif
    endtask

    initial begin
        int dcount;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = 2'b00;
        exp_n = 1'b0;
        exp_z = 1'b0;
        exp_v = 1'b0;
        last_exp = '0;
`ifdef SAT_ADDSUB_STICKY_EN
        clr_sticky = 1'b0;
        exp_sticky = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.res", result, 0);
        check("rst.NZV", {N, Z, V}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(16'd20000, 16'd10000, 2'b00, 0, "add");
        run_op(16'd20000, 16'd10000, 2'b01, 0, "sub");
        run_op(16'd5,     16'd5,     2'b01, 0, "sub_zero");
        run_op(16'h7FFF,  16'd100,   2'b00, 0, "add_posmax");
        run_op(16'h8001,  16'hFB2E,  2'b00, 0, "add_negmin");
        run_op(16'h7F12,  16'h1F34,  2'b10, 0, "padd");
        check("padd.exact", result, 16'h7E46);
        run_op(16'h0000,  16'h8000,  2'b01, 0, "sub_minneg");
        check("sub_minneg.exact", result, 16'h7FFF);

        // start pulsed while busy must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'd1234; b = 16'd4321; op = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;            // cycle 2 of the op
        start = 1'b1; a = 16'h7000; b = 16'h7000; op = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        if (done) dcount++;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dcount++;
                check("ign.res", result, 16'd5555);
            end
        end
        exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
        $display("[TB] ignored-start done count=%0d", dcount);
        check("ign.dones", dcount, 1);
        check("ign.busy", busy, 0);

        // back-to-back: second start issued in the done cycle
        run_op(16'd300, 16'd200, 2'b00, 0, "b2b_first");
        run_op(16'h8000, 16'h0001, 2'b01, 1, "b2b_second");

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; op = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mrst.busy", busy, 0);
        check("mrst.res", result, 0);
        check("mrst.NZV", {N, Z, V}, 0);
        exp_n = 1'b0; exp_z = 1'b0; exp_v = 1'b0;
`ifdef SAT_ADDSUB_STICKY_EN
        check("mrst.sticky", ovf_sticky, 0);
        exp_sticky = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        $display("[TB] post-reset done count=%0d", dcount);
        check("mrst.nodone", dcount, 0);

        // randomized ops, with boundary values mixed in
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'h7FFF;
                1: rb = 16'h8000;
                2: begin ra = 16'h8888; rb = 16'h7777; end
                default: ;
            endcase
            run_op(ra, rb, 2'($urandom), ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
